// File: rtl/g729_pkg.sv
// Shared constants and state encoding for the speech-frame front end.
// Buffer depth is one analysis window plus one frame of headroom.
package g729_pkg;

    localparam int DW        = 16;
    localparam int FRAME_LEN = 80;
    localparam int WIN_LEN   = 240;
    localparam int BUF_DEPTH = WIN_LEN + FRAME_LEN;

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } fb_state_t;

endpackage

// File: rtl/frame_buf_sample_ram.sv
// Simple dual-port sample store: one synchronous write port, one registered
// read port. A same-address read and write return the old content.
module sample_ram #(
    parameter int DEPTH = g729_pkg::BUF_DEPTH,
    parameter int DW    = g729_pkg::DW,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/frame_buf.sv
// Circular sample buffer that latches a sliding LPC analysis window every
// frame and exposes it through a one-cycle-latency random-access read port.
module frame_buf #(
    parameter int DW        = g729_pkg::DW,
    parameter int FRAME_LEN = g729_pkg::FRAME_LEN,
    parameter int WIN_LEN   = g729_pkg::WIN_LEN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [DW-1:0] sample_in,
    output logic          frame_ready,
    input  logic          frame_ack,
    input  logic          rd_req,
    input  logic [7:0]    rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic [7:0]    frame_num,
    output logic          overrun
);

    localparam int DEPTH = WIN_LEN + FRAME_LEN;
    localparam int AW    = $clog2(DEPTH);
    localparam int FW    = $clog2(FRAME_LEN);
    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [AW:0] WIN_X   = (AW+1)'(WIN_LEN);

    g729_pkg::fb_state_t state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FW-1:0] frm_cnt_q, frm_cnt_d;
    logic [AW-1:0] prime_cnt_q, prime_cnt_d;
    logic [AW-1:0] win_base_q, win_base_d;
    logic [7:0]    frame_num_q, frame_num_d;
    logic          overrun_q, overrun_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_mask_q, rd_mask_d;

    logic          frame_done;
    logic [AW-1:0] wr_ptr_nx;
    logic [AW:0]   base_sum;
    logic [AW-1:0] new_base;
    logic [AW:0]   addr_x;
    logic [AW:0]   rd_sum;
    logic [AW-1:0] rd_phys;
    logic [DW-1:0] ram_rdata;

    assign wr_ptr_nx  = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    assign frame_done = ce && (frm_cnt_q == FW'(FRAME_LEN - 1));

    // Window start = newest write position minus WIN_LEN, kept non-negative.
    assign base_sum = {1'b0, wr_ptr_nx} + DEPTH_X - WIN_X;
    assign new_base = (base_sum >= DEPTH_X) ? AW'(base_sum - DEPTH_X) : base_sum[AW-1:0];

    assign addr_x  = {{(AW-7){1'b0}}, rd_addr};
    assign rd_sum  = {1'b0, win_base_q} + addr_x;
    assign rd_phys = (rd_sum >= DEPTH_X) ? AW'(rd_sum - DEPTH_X) : rd_sum[AW-1:0];

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        frm_cnt_d   = frm_cnt_q;
        prime_cnt_d = prime_cnt_q;
        win_base_d  = win_base_q;
        frame_num_d = frame_num_q;
        overrun_d   = overrun_q;
        rd_valid_d  = rd_req;
        rd_mask_d   = rd_req ? (addr_x >= WIN_X) : rd_mask_q;

        if (ce) begin
            wr_ptr_d  = wr_ptr_nx;
            frm_cnt_d = frame_done ? '0 : frm_cnt_q + 1'b1;
        end

        case (state_q)
            g729_pkg::ST_PRIME: begin
                if (ce) begin
                    prime_cnt_d = prime_cnt_q + 1'b1;
                end
                if (frame_done && (prime_cnt_q == AW'(WIN_LEN - 1))) begin
                    state_d     = g729_pkg::ST_READY;
                    win_base_d  = new_base;
                    frame_num_d = frame_num_q + 8'd1;
                end
            end
            g729_pkg::ST_WAIT: begin
                if (frame_done) begin
                    state_d     = g729_pkg::ST_READY;
                    win_base_d  = new_base;
                    frame_num_d = frame_num_q + 8'd1;
                end
            end
            g729_pkg::ST_READY: begin
                // A completing frame beats a coincident ack; only an unacked
                // replacement counts as an overrun.
                if (frame_done) begin
                    win_base_d  = new_base;
                    frame_num_d = frame_num_q + 8'd1;
                    if (!frame_ack) begin
                        overrun_d = 1'b1;
                    end
                end else if (frame_ack) begin
                    state_d = g729_pkg::ST_WAIT;
                end
            end
            default: state_d = g729_pkg::ST_PRIME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= g729_pkg::ST_PRIME;
            wr_ptr_q    <= '0;
            frm_cnt_q   <= '0;
            prime_cnt_q <= '0;
            win_base_q  <= '0;
            frame_num_q <= '0;
            overrun_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_mask_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            frm_cnt_q   <= frm_cnt_d;
            prime_cnt_q <= prime_cnt_d;
            win_base_q  <= win_base_d;
            frame_num_q <= frame_num_d;
            overrun_q   <= overrun_d;
            rd_valid_q  <= rd_valid_d;
            rd_mask_q   <= rd_mask_d;
        end
    end

    sample_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ce && !rst),
        .waddr (wr_ptr_q),
        .wdata (sample_in),
        .re    (rd_req && !rst),
        .raddr (rd_phys),
        .rdata (ram_rdata)
    );

    // The mask doubles as the reset value of rd_data and the out-of-range zero.
    assign rd_data     = rd_mask_q ? '0 : ram_rdata;
    assign rd_valid    = rd_valid_q;
    assign frame_ready = (state_q == g729_pkg::ST_READY);
    assign frame_num   = frame_num_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_buf.sv
// Randomized bench for frame_buf: a sample-history model predicts window
// contents and status; read responses are checked from a scoreboard queue.
module tb_frame_buf;

    localparam int DW = 16;
    localparam int FL = 80;
    localparam int WL = 240;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic [DW-1:0] sample_in;
    logic          frame_ready;
    logic          frame_ack;
    logic          rd_req;
    logic [7:0]    rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [7:0]    frame_num;
    logic          overrun;

    always #5 clk = ~clk;

    frame_buf dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .sample_in   (sample_in),
        .frame_ready (frame_ready),
        .frame_ack   (frame_ack),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .frame_num   (frame_num),
        .overrun     (overrun)
    );

    typedef struct {
        int          cyc;
        bit          chk;
        logic [15:0] exp;
        int          addr;
    } rd_exp_t;

    rd_exp_t sbq[$];
    rd_exp_t mon_e;
    int n_vec = 0;
    int n_bad = 0;
    int cyc_cnt = 0;

    // Reference model: every sample since reset, plus where the latched window starts.
    logic [15:0] hist[$];
    int  m_n;
    int  m_win_start;
    bit  m_have_win;
    bit  m_ready;
    int  m_fnum;
    bit  m_ovr;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: every request must be answered exactly one cycle later.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rd_valid_spurious cyc=%0d actual rd_valid=1 required 0", cyc_cnt);
            end else begin
                mon_e = sbq.pop_front();
                n_vec++;
                if (mon_e.cyc != cyc_cnt - 1) begin
                    n_bad++;
                    $display("FAIL rd_latency addr=%0d actual cycle %0d required %0d",
                             mon_e.addr, cyc_cnt, mon_e.cyc + 1);
                end else if (mon_e.chk && rd_data !== mon_e.exp) begin
                    n_bad++;
                    $display("FAIL rd_data addr=%0d actual %0d required %0d",
                             mon_e.addr, rd_data, mon_e.exp);
                end
            end
        end else if (sbq.size() > 0 && sbq[0].cyc <= cyc_cnt - 1) begin
            mon_e = sbq.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL rd_valid_missing addr=%0d actual rd_valid=0 required 1", mon_e.addr);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_n = 0;
        m_win_start = 0;
        m_have_win = 0;
        m_ready = 0;
        m_fnum = 0;
        m_ovr = 0;
    endtask

    // One clock cycle of stimulus; status outputs are checked #1 after the edge.
    task automatic step(input bit r, input bit c, input logic [15:0] d,
                        input bit a, input bit q, input logic [7:0] ad);
        rd_exp_t e;
        rst = r; ce = c; sample_in = d; frame_ack = a; rd_req = q; rd_addr = ad;
        if (!r && q) begin
            e.cyc  = cyc_cnt;
            e.addr = ad;
            if (ad >= WL) begin
                e.chk = 1; e.exp = '0;
            end else if (m_have_win) begin
                e.chk = 1; e.exp = hist[m_win_start + ad];
            end else begin
                e.chk = 0; e.exp = '0;
            end
            sbq.push_back(e);
        end
        if (r) begin
            model_reset();
        end else begin
            if (c) begin
                hist.push_back(d);
                m_n++;
            end
            if (c && (m_n % FL == 0) && m_n >= WL) begin
                m_win_start = m_n - WL;
                m_have_win = 1;
                if (m_ready && !a) m_ovr = 1;
                m_ready = 1;
                m_fnum = (m_fnum + 1) % 256;
            end else if (a && m_ready) begin
                m_ready = 0;
            end
        end
        @(posedge clk);
        #1;
        check("frame_ready", 32'(frame_ready), 32'(m_ready));
        check("frame_num", 32'(frame_num), 32'(m_fnum));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0);
    endtask

    initial begin
        rst = 1; ce = 0; sample_in = '0; frame_ack = 0; rd_req = 0; rd_addr = '0;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1, 0, '0, 0, 0, '0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);

        // Priming with 1..240 plus sparse reads
        for (int i = 1; i <= WL; i++)
            step(0, 1, 16'(i), 0, $urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)));
        step(0, 0, '0, 0, 1, 8'd0);
        step(0, 0, '0, 0, 1, 8'd239);
        idle(2);

        // Ack coinciding with frame completion
        for (int i = 0; i < FL; i++)
            step(0, 1, 16'(500 + i), i == FL - 1, 0, '0);
        idle(1);

        // Window isolation under concurrent writes, ending in an overrun
        for (int i = 0; i < FL; i++)
            step(0, 1, 16'(1000 + i), 0, 1, 8'($urandom_range(0, WL - 1)));
        step(0, 0, '0, 0, 1, 8'd0);
        idle(2);

        // Randomized traffic across pointer wrap
        step(1, 0, '0, 0, 0, '0);
        for (int i = 0; i < 2000; i++)
            step(0, $urandom_range(0, 3) != 0, 16'($urandom),
                 m_ready && ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));
        step(0, 0, '0, 0, 1, 8'd250);
        idle(2);

        // Mid-frame reset with a read issued alongside it
        for (int i = 0; i < FL / 2; i++) step(0, 1, 16'($urandom), 0, 0, '0);
        step(1, 0, '0, 0, 1, 8'd0);
        check("midrst_rd_valid", 32'(rd_valid), 32'd0);
        check("midrst_rd_data", 32'(rd_data), 32'd0);
        for (int i = 0; i < WL; i++)
            step(0, 1, 16'($urandom), 0, $urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)));
        step(0, 0, '0, 0, 1, 8'd5);
        idle(3);

        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_buf.md
FRAME_BUF -- requirements
Module: frame_buf

Interface
REQ-001 SHALL have parameter DW, default 16, sample width in bits.
REQ-002 SHALL have parameter FRAME_LEN, default 80, samples per 10 ms frame.
REQ-003 SHALL have parameter WIN_LEN, default 240, LPC analysis window length in samples.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port ce, input, 1, sample strobe; sample_in is valid in this cycle.
REQ-007 SHALL have port sample_in, input, DW, pre-processed two's-complement sample from the pre-processing stage.
REQ-008 SHALL have port frame_ready, output, 1, a complete window is latched and readable.
REQ-009 SHALL have port frame_ack, input, 1, single-cycle pulse from the consumer that releases the window.
REQ-010 SHALL have port rd_req, input, 1, window read request.
REQ-011 SHALL have port rd_addr, input, 8, window index: 0 is the oldest sample, WIN_LEN-1 the newest.
REQ-012 SHALL have port rd_data, output, DW, read data.
REQ-013 SHALL have port rd_valid, output, 1, rd_data is valid.
REQ-014 SHALL have port frame_num, output, 8, count of completed windows, wrapping.
REQ-015 SHALL have port overrun, output, 1, sticky flag: a window was replaced before it was acked.

Function
REQ-016 SHALL store samples in a circular buffer of depth BUF_DEPTH = WIN_LEN + FRAME_LEN (320), using a 9-bit write pointer wr_ptr.
REQ-017 SHALL, on ce, write sample_in at wr_ptr, advance wr_ptr wrapping 319 -> 0, and advance the in-frame counter (0..FRAME_LEN-1).
REQ-018 SHALL implement a state machine with states PRIME, WAIT and READY.
REQ-019 SHALL stay in PRIME until WIN_LEN samples have been written since reset (three frames); completion of the third frame moves it to READY.
REQ-020 SHALL treat the cycle in which the FRAME_LEN-th sample of a frame is written as frame completion.
REQ-021 SHALL, at frame completion in WAIT or READY:
- set win_base = (wr_ptr_after_write - WIN_LEN) mod BUF_DEPTH;
- increment frame_num;
- go to READY.
REQ-022 SHALL, on frame_ack in READY with no simultaneous completion, clear frame_ready and go to WAIT.
REQ-023 SHALL ignore frame_ack in PRIME and WAIT.
REQ-024 SHALL, on frame completion while READY and frame_ack is not asserted in the same cycle, set overrun and rebase the window to the newest data.
REQ-025 SHALL, when frame completion and frame_ack coincide, let completion win: frame_ready stays 1, the window rebases, and overrun is not set.
REQ-026 SHALL drive frame_ready as 1 exactly when the state is READY.
REQ-027 SHALL guarantee that writes for the next frame never alter the latched window (the 80 spare slots absorb them).
REQ-028 SHALL return the sample at physical address (win_base + rd_addr) mod BUF_DEPTH, with rd_data and rd_valid registered exactly one cycle after rd_req.
REQ-029 SHALL, for rd_addr >= WIN_LEN, return rd_data = 0 with rd_valid = 1.
REQ-030 SHALL service reads in any state, returning stale or uninitialised data outside READY.
REQ-031 SHALL allow a simultaneous write and read in the same cycle; a read of the same physical slot returns the old content.
REQ-032 SHALL leave overrun set until rst.

Reset
REQ-033 SHALL, on rst:
- force state to PRIME;
- clear wr_ptr, the in-frame counter, the priming counter and win_base;
- drive frame_ready, rd_valid, rd_data, frame_num and overrun to 0.
REQ-034 SHALL NOT reset the buffer memory.
REQ-035 SHALL, on rst mid-frame or mid-read, discard the partial frame and require full re-priming; a read pending at reset yields no rd_valid.

Structure
REQ-036 SHALL take DW, FRAME_LEN, WIN_LEN, BUF_DEPTH and the state enum from shared package g729_pkg.
REQ-037 SHALL instantiate one sub-module, sample_ram: BUF_DEPTH x DW, one synchronous write port and one synchronous read port, read-before-write.

Verification
REQ-038 Priming: 239 ce samples with values 1..239 -> frame_ready = 0; the 240th -> frame_ready = 1 the next cycle and frame_num = 1.
REQ-039 Read order: after priming with samples 1..240, rd_addr 0 -> rd_data = 1 and rd_addr 239 -> 240, each one cycle after rd_req.
REQ-040 Window isolation: while READY, write 80 more samples (1000..1079) during reads -> reads still return 1..240; at the 80th sample with no ack -> overrun = 1 and rd_addr 0 returns 81.
REQ-041 Ack/complete collision: frame_ack asserted in the same cycle as frame completion -> frame_ready stays 1, overrun = 0, frame_num increments.
REQ-042 Wrap and out-of-range: run 10 frames with ack -> correct window across the 319 -> 0 wrap; rd_addr 250 -> rd_data = 0, rd_valid = 1.
REQ-043 Mid-frame reset: rst after 40 samples of frame 5 -> all outputs 0, and the next frame_ready appears only after 240 new samples.
